bf_exec_ctrl: RTL and testbench

Execution controller for the brainfuck core. Converts the debounced single-cycle button pulses (load, start/pause, step) into a sequenced reset → program-load → run/pause/step → done lifecycle. Drives the core's reset, load request and run enable. Exports state and retired-instruction count for the LEDs and PMOD display, and sits between the button debouncers and the core inside `top`.

---
 rtl/bf_pkg.sv | 23 ++
 rtl/bf_timer.sv | 27 ++
 rtl/bf_exec_ctrl.sv | 133 +++++++++++++
 tb/tb_bf_exec_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core, its execution controller and the
// LED/PMOD display logic that decodes state_id.
package bf_pkg;

  localparam int BF_STATE_W = 3;
  localparam int BF_CNT_W   = 24;

  typedef enum logic [BF_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } bf_state_e;

  function automatic logic state_is_busy(bf_state_e s);
    return (s == ST_CRST) || (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/bf_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module bf_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/bf_exec_ctrl.sv
// Execution controller: turns debounced button pulses into the core's
// reset -> load -> run/pause/step -> done lifecycle and counts retirements.
module bf_exec_ctrl
  import bf_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int LOAD_TIMEOUT = 65535,
  parameter int CNT_W        = BF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  load_pulse,
  input  logic                  start_pulse,
  input  logic                  step_pulse,
  input  logic                  core_loaded,
  input  logic                  core_halted,
  input  logic                  core_retire,
  output logic                  core_rst,
  output logic                  core_load_req,
  output logic                  core_run,
  output logic [BF_STATE_W-1:0] state_id,
  output logic [CNT_W-1:0]      insn_count,
  output logic                  fault,
  output logic                  busy
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W  = $clog2(LOAD_TIMEOUT + 1);

  bf_state_e  state_reg, state_next;
  logic       step_reg, step_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic       crst_start, load_start;
  logic       crst_done, to_done;
  logic       core_rst_reg, load_req_reg, fault_reg, busy_reg;

  // Both timers are preloaded with N-1 so the state lasts exactly N cycles.
  bf_timer #(.W(RST_W)) u_crst_timer (
    .clk      (CLK),
    .rst      (rst),
    .load     (crst_start),
    .load_val (RST_W'(RST_CYCLES - 1)),
    .en       (state_reg == ST_CRST),
    .done     (crst_done)
  );

  bf_timer #(.W(TO_W)) u_load_timer (
    .clk      (CLK),
    .rst      (rst),
    .load     (load_start),
    .load_val (TO_W'(LOAD_TIMEOUT - 1)),
    .en       (state_reg == ST_LOAD),
    .done     (to_done)
  );

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    case (state_reg)
      ST_IDLE: if (load_pulse) state_next = ST_CRST;
      ST_CRST: if (crst_done) state_next = ST_LOAD;
      ST_LOAD: begin
        if (core_loaded)  state_next = ST_READY;
        else if (to_done) state_next = ST_FAULT;
      end
      ST_READY, ST_PAUSE: begin
        if (load_pulse) begin
          state_next = ST_CRST;
        end else if (start_pulse) begin
          state_next = ST_RUN;
          step_next  = 1'b0;
        end else if (step_pulse) begin
          state_next = ST_RUN;
          step_next  = 1'b1;
        end
      end
      ST_RUN: begin
        // A step request while already running outranks the stepping retire
        // and simply keeps the core running for one more instruction.
        if (load_pulse)                    state_next = ST_CRST;
        else if (core_halted)              state_next = ST_DONE;
        else if (start_pulse)              state_next = ST_PAUSE;
        else if (step_pulse)               state_next = ST_RUN;
        else if (step_reg && core_retire)  state_next = ST_PAUSE;
      end
      ST_DONE, ST_FAULT: if (load_pulse) state_next = ST_CRST;
      default: state_next = ST_IDLE;
    endcase

    crst_start = (state_next == ST_CRST) && (state_reg != ST_CRST);
    load_start = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
    if (crst_start) step_next = 1'b0;
  end

  always_comb begin
    count_next = count_reg;
    if (crst_start || (state_reg == ST_CRST)) begin
      count_next = '0;
    end else if ((state_reg == ST_RUN) && core_retire && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      step_reg     <= 1'b0;
      count_reg    <= '0;
      core_rst_reg <= 1'b0;
      load_req_reg <= 1'b0;
      fault_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      count_reg    <= count_next;
      core_rst_reg <= (state_next == ST_CRST);
      load_req_reg <= (state_next == ST_LOAD);
      fault_reg    <= (state_next == ST_FAULT);
      busy_reg     <= state_is_busy(state_next);
    end
  end

  // core_run drops in the stepping retire cycle so one step is one instruction.
  assign core_run      = (state_reg == ST_RUN) && !(step_reg && core_retire);
  assign core_rst      = core_rst_reg;
  assign core_load_req = load_req_reg;
  assign fault         = fault_reg;
  assign busy          = busy_reg;
  assign state_id      = state_reg;
  assign insn_count    = count_reg;

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Scoreboard bench for bf_exec_ctrl: two instances (24-bit and 4-bit counters)
// share all stimulus; expected values are queued and compared after each edge.
module tb_bf_exec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_pulse = 1'b0, start_pulse = 1'b0, step_pulse = 1'b0;
  logic core_loaded = 1'b0, core_halted = 1'b0, core_retire = 1'b0;

  logic        a_core_rst, a_load_req, a_core_run, a_fault, a_busy;
  logic [2:0]  a_state;
  logic [23:0] a_count;
  logic        b_core_rst, b_load_req, b_core_run, b_fault, b_busy;
  logic [2:0]  b_state;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bf_exec_ctrl #(.RST_CYCLES(4), .LOAD_TIMEOUT(100), .CNT_W(24)) dut_a (
    .CLK(clk), .rst(rst), .load_pulse(load_pulse), .start_pulse(start_pulse),
    .step_pulse(step_pulse), .core_loaded(core_loaded), .core_halted(core_halted),
    .core_retire(core_retire), .core_rst(a_core_rst), .core_load_req(a_load_req),
    .core_run(a_core_run), .state_id(a_state), .insn_count(a_count),
    .fault(a_fault), .busy(a_busy)
  );

  bf_exec_ctrl #(.RST_CYCLES(4), .LOAD_TIMEOUT(100), .CNT_W(4)) dut_b (
    .CLK(clk), .rst(rst), .load_pulse(load_pulse), .start_pulse(start_pulse),
    .step_pulse(step_pulse), .core_loaded(core_loaded), .core_halted(core_halted),
    .core_retire(core_retire), .core_rst(b_core_rst), .core_load_req(b_load_req),
    .core_run(b_core_run), .state_id(b_state), .insn_count(b_count),
    .fault(b_fault), .busy(b_busy)
  );

  typedef enum {S_STATE, S_CNT, S_CNTB, S_STATEB, S_CRST, S_LREQ, S_RUN, S_FAULT, S_BUSY} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, act);
    end
  endtask

  task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_STATE:  return 32'(a_state);
      S_CNT:    return 32'(a_count);
      S_CNTB:   return 32'(b_count);
      S_STATEB: return 32'(b_state);
      S_CRST:   return 32'(a_core_rst);
      S_LREQ:   return 32'(a_load_req);
      S_RUN:    return 32'(a_core_run);
      S_FAULT:  return 32'(a_fault);
      default:  return 32'(a_busy);
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
    for (int i = 0; i < bound && a_state != target; i++) cyc();
    expect_sig(tag, S_STATE, 32'(target));
    drain();
  endtask

  task automatic goto_ready();
    core_loaded = 1'b0;
    load_pulse  = 1'b1;
    cyc();
    load_pulse  = 1'b0;
    wait_state("to_load", 3'd2, 20);
    core_loaded = 1'b1;
    cyc();
    expect_sig("ready", S_STATE, 3);
    drain();
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
  endtask

  int n;

  initial begin
    // 1. reset
    repeat (3) cyc();
    rst = 1'b0;
    expect_sig("rst_state", S_STATE, 0);
    expect_sig("rst_crst", S_CRST, 0);
    expect_sig("rst_lreq", S_LREQ, 0);
    expect_sig("rst_run", S_RUN, 0);
    expect_sig("rst_fault", S_FAULT, 0);
    expect_sig("rst_busy", S_BUSY, 0);
    expect_sig("rst_cnt", S_CNT, 0);
    drain();
    repeat (5) cyc();
    expect_sig("idle_hold", S_STATE, 0);
    expect_sig("idle_busy", S_BUSY, 0);
    drain();

    // 2. normal run
    load_pulse = 1'b1;
    cyc();
    load_pulse = 1'b0;
    expect_sig("crst_state", S_STATE, 1);
    expect_sig("crst_busy", S_BUSY, 1);
    drain();
    n = 0;
    for (int i = 0; i < 20 && a_core_rst; i++) begin
      n++;
      cyc();
    end
    check("crst_len", n, 4);
    expect_sig("load_state", S_STATE, 2);
    expect_sig("load_req", S_LREQ, 1);
    drain();
    repeat (9) cyc();
    core_loaded = 1'b1;
    cyc();
    expect_sig("ready_state", S_STATE, 3);
    expect_sig("ready_lreq", S_LREQ, 0);
    drain();
    pulse_start();
    expect_sig("run_state", S_STATE, 4);
    expect_sig("run_run", S_RUN, 1);
    drain();
    for (int i = 0; i < 37; i++) begin
      core_retire = 1'b1;
      cyc();
      core_retire = 1'b0;
      cyc();
    end
    expect_sig("run_cnt", S_CNT, 37);
    expect_sig("run_cnt_sat", S_CNTB, 15);
    drain();
    core_halted = 1'b1;
    cyc();
    core_halted = 1'b0;
    expect_sig("done_state", S_STATE, 6);
    expect_sig("done_run", S_RUN, 0);
    expect_sig("done_busy", S_BUSY, 0);
    expect_sig("done_cnt", S_CNT, 37);
    drain();

    // 3. single step
    goto_ready();
    for (int s = 0; s < 3; s++) begin
      step_pulse = 1'b1;
      cyc();
      step_pulse = 1'b0;
      expect_sig("step_run", S_STATE, 4);
      expect_sig("step_run_en", S_RUN, 1);
      drain();
      repeat (4) cyc();
      core_retire = 1'b1;
      #1;
      expect_sig("step_retire_run", S_RUN, 0);
      drain();
      cyc();
      core_retire = 1'b0;
      expect_sig("step_pause", S_STATE, 5);
      drain();
    end
    expect_sig("step_cnt", S_CNT, 3);
    expect_sig("step_cnt_b", S_CNTB, 3);
    drain();

    // 4. load timeout, abort from PAUSE
    core_loaded = 1'b0;
    load_pulse  = 1'b1;
    cyc();
    load_pulse  = 1'b0;
    expect_sig("abort_pause", S_STATE, 1);
    drain();
    wait_state("to_load2", 3'd2, 20);
    n = 0;
    for (int i = 0; i < 200 && a_state == 3'd2; i++) begin
      n++;
      cyc();
    end
    check("load_len", n, 100);
    expect_sig("fault_state", S_STATE, 7);
    expect_sig("fault_flag", S_FAULT, 1);
    expect_sig("fault_busy", S_BUSY, 0);
    drain();
    load_pulse = 1'b1;
    cyc();
    load_pulse = 1'b0;
    expect_sig("fault_reload", S_STATE, 1);
    expect_sig("fault_clr", S_FAULT, 0);
    drain();

    // loaded arriving in the final timeout cycle wins
    wait_state("to_load3", 3'd2, 20);
    repeat (99) cyc();
    core_loaded = 1'b1;
    cyc();
    expect_sig("late_loaded", S_STATE, 3);
    expect_sig("late_fault", S_FAULT, 0);
    drain();

    // 5. simultaneous events
    goto_ready();
    pulse_start();
    core_halted = 1'b1;
    start_pulse = 1'b1;
    core_retire = 1'b1;
    cyc();
    core_halted = 1'b0;
    start_pulse = 1'b0;
    core_retire = 1'b0;
    expect_sig("simul_done", S_STATE, 6);
    expect_sig("simul_cnt", S_CNT, 1);
    drain();
    goto_ready();
    pulse_start();
    pulse_start();
    expect_sig("pause_state", S_STATE, 5);
    drain();
    load_pulse  = 1'b1;
    start_pulse = 1'b1;
    cyc();
    load_pulse  = 1'b0;
    start_pulse = 1'b0;
    expect_sig("load_wins", S_STATE, 1);
    drain();

    // 6. saturation and mid-run abort
    goto_ready();
    pulse_start();
    core_retire = 1'b1;
    repeat (20) cyc();
    core_retire = 1'b0;
    expect_sig("sat_cnt_b", S_CNTB, 15);
    expect_sig("sat_cnt_a", S_CNT, 20);
    expect_sig("sat_state_b", S_STATEB, 4);
    drain();
    load_pulse = 1'b1;
    cyc();
    load_pulse = 1'b0;
    expect_sig("abort_state", S_STATE, 1);
    expect_sig("abort_cnt_b", S_CNTB, 0);
    expect_sig("abort_cnt_a", S_CNT, 0);
    expect_sig("abort_run", S_RUN, 0);
    expect_sig("abort_crst", S_CRST, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
